convolution_2d_result_writer: RTL and testbench
===============================================

# convolution_2d_result_writer

Write-side data mover for the 2-D convolution engine. Accepts the stream of result words from the convolution datapath and writes it to memory over the AXI4 write-only result master port (m_axi_rst). Output is incrementing bursts, split at MAX_BURST beats and at 4 KB boundaries, with one burst outstanding at a time. The block signals completion, and any error response, back to the control/interrupt logic.

## Interface
Parameters:
- AXI_WIDTH_ID, 4: AXI ID width.
- AXI_WIDTH_AD, 32: AXI address width.
- AXI_WIDTH_DA, 32: AXI data width, and the width of the result word.
- AXI_WIDTH_DS, AXI_WIDTH_DA/8: write-strobe width, bytes per beat.
- AXI_ID, 0: constant value driven on AWID.
- MAX_BURST, 16: maximum beats per burst, 1..256.
- CNT_WIDTH, 16: width of the word-count input.

Ports (clock and reset first):
- ACLK  in  1  clock.
- ARESET  in  1  reset. One clock domain (ACLK); ARESET is synchronous to ACLK and active-high.
- start  in  1  single-cycle pulse that begins a transfer. Honoured only in IDLE.
- base_addr  in  AXI_WIDTH_AD  start byte address, aligned to AXI_WIDTH_DS. Sampled on start.
- num_words  in  CNT_WIDTH  number of result words to write. Sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transfer finishes.
- error  out  1  sticky; set by any BRESP != OKAY; cleared by an accepted start.
- in_data  in  AXI_WIDTH_DA  result word.
- in_valid  in  1  result word available.
- in_ready  out  1  result word consumed.
- M_AXI_RST_AWID/AWADDR/AWLEN[7:0]/AWSIZE[2:0]/AWBURST[1:0]/AWVALID  out; AWREADY  in: AXI4 write-address channel.
- M_AXI_RST_WDATA/WSTRB/WLAST/WVALID  out; WREADY  in: AXI4 write-data channel.
- M_AXI_RST_BID/BRESP[1:0]/BVALID  in; BREADY  out: AXI4 write-response channel.

## Operation
- Constant outputs:
  - AWID = AXI_ID.
  - AWSIZE = log2(AXI_WIDTH_DS).
  - AWBURST = 2'b01 (INCR).
  - WSTRB = all ones.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On start with num_words != 0: latch addr = base_addr and remaining = num_words, clear error, go to ADDR.
  - On start with num_words == 0: clear error, pulse done the next cycle, issue no AXI traffic.
- ADDR:
  - Burst length is len = min(remaining, MAX_BURST, (4096 - addr[11:0]) / AXI_WIDTH_DS).
  - AWADDR = addr, AWLEN = len-1. Both are registered when entering ADDR and held stable while AWVALID=1.
  - On AWVALID && AWREADY, go to DATA; beat counter = len.
- DATA: pass-through, no buffering.
  - WVALID = in_valid, WDATA = in_data, in_ready = WREADY.
  - in_ready and WVALID are 0 in every other state.
  - WLAST = 1 when beat counter == 1.
  - On each W handshake, decrement the beat counter and remaining.
  - On the last beat, go to RESP.
- RESP:
  - BREADY = 1.
  - On BVALID: if BRESP != 2'b00, set error.
  - Then addr += len*AXI_WIDTH_DS. If remaining == 0, pulse done and go to IDLE; otherwise go to ADDR.
- Ordering: exactly one burst is outstanding at a time; the next AW is not issued before the previous B. BID is ignored.
- A start pulse while busy is ignored.
- An error response does not abort the transfer; all remaining bursts are still issued.
- Arithmetic: addr wraps modulo 2^AXI_WIDTH_AD. remaining and the beat counter never underflow, because len ≤ remaining.

## Timing
- Reset values:
  - AWVALID, WVALID, WLAST, BREADY, in_ready, busy, done, error = 0.
  - AWADDR = 0, AWLEN = 0.
  - FSM = IDLE.
- Reset asserted mid-burst forces all of the reset values on the next edge. Any partial burst is abandoned; the interconnect is reset alongside.
- start at cycle 0 → busy=1 and AWVALID=1 at cycle 1.
- AW handshake at cycle t → DATA is active (WVALID may be 1) at t+1.
- Last W handshake at cycle t → BREADY=1 at t+1.
- B handshake at cycle t:
  - If more data remains, AWVALID=1 for the next burst at t+1.
  - Otherwise done=1 and busy=0 at t+1.
- Zero-count start at cycle 0 → done=1 at cycle 1, busy stays 0.
- Once asserted, AWVALID stays high until AWREADY; AWADDR and AWLEN are stable during that time.
- Throughput is one beat per cycle when in_valid and WREADY are both held high.

## Test plan
- Bursting: base 0x1000, num_words 40, MAX_BURST 16, all ready/valid held high.
  - Required AW sequence (AWADDR/AWLEN): 0x1000/15, 0x1040/15, 0x1080/7.
  - WLAST on beats 16, 32 and 40; 40 words written in order; done once; error=0.
- 4 KB split: base 0x0FF8, num_words 10.
  - Required AW sequence: 0x0FF8/AWLEN 1, then 0x1000/AWLEN 7.
- Zero count: num_words 0.
  - done=1 exactly one cycle after start; AWVALID never asserted.
- Error response: base 0x2000, num_words 32, BRESP=2'b10 on the first burst.
  - Second burst still issued; error=1 at done.
  - A following start clears error.
- Backpressure: random in_valid/WREADY/AWREADY/BVALID stalls, num_words 100.
  - Memory contents equal the input sequence; AWADDR/AWLEN stable while stalled; one burst outstanding at most.
- Reset mid-burst: ARESET at beat 5 of the first burst.
  - All outputs return to reset values next cycle.
  - A new start afterwards completes normally.
  - A start pulse sent during busy is ignored.

Source files
------------

// File: rtl/convolution_2d_result_writer.sv
// AXI4 write-only master for the 2-D convolution result stream.
// Emits INCR bursts split at MAX_BURST beats and 4 KB pages, one burst outstanding at a time.
module convolution_2d_result_writer #(
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int AXI_WIDTH_DS = AXI_WIDTH_DA / 8,
    parameter int AXI_ID       = 0,
    parameter int MAX_BURST    = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [AXI_WIDTH_AD-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]    num_words,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic [AXI_WIDTH_DA-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [AXI_WIDTH_ID-1:0] M_AXI_RST_AWID,
    output logic [AXI_WIDTH_AD-1:0] M_AXI_RST_AWADDR,
    output logic [7:0]              M_AXI_RST_AWLEN,
    output logic [2:0]              M_AXI_RST_AWSIZE,
    output logic [1:0]              M_AXI_RST_AWBURST,
    output logic                    M_AXI_RST_AWVALID,
    input  logic                    M_AXI_RST_AWREADY,
    output logic [AXI_WIDTH_DA-1:0] M_AXI_RST_WDATA,
    output logic [AXI_WIDTH_DS-1:0] M_AXI_RST_WSTRB,
    output logic                    M_AXI_RST_WLAST,
    output logic                    M_AXI_RST_WVALID,
    input  logic                    M_AXI_RST_WREADY,
    input  logic [AXI_WIDTH_ID-1:0] M_AXI_RST_BID,
    input  logic [1:0]              M_AXI_RST_BRESP,
    input  logic                    M_AXI_RST_BVALID,
    output logic                    M_AXI_RST_BREADY,
    output logic [1:0]              state_dbg
);

    localparam int SIZE = $clog2(AXI_WIDTH_DS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  state;
    logic [AXI_WIDTH_AD-1:0] addr_q;
    logic [CNT_WIDTH-1:0]    rem_q;
    logic [8:0]              len_q;
    logic [8:0]              beat_q;
    logic                    awvalid_q;
    logic [AXI_WIDTH_AD-1:0] awaddr_q;
    logic [7:0]              awlen_q;
    logic                    done_q;
    logic                    error_q;

    logic [AXI_WIDTH_AD-1:0] next_addr;
    logic [8:0]              len_start;
    logic [8:0]              len_next;
    logic                    w_fire;
    logic                    unused_bid;

    // Beats allowed from this address: the smallest of words left, MAX_BURST
    // and the room before the next 4 KB page.
    function automatic logic [8:0] calc_len(input logic [11:0] page_off,
                                            input logic [CNT_WIDTH-1:0] rem);
        logic [12:0] room;
        logic [31:0] lim;
        room = (13'd4096 - {1'b0, page_off}) >> SIZE;
        lim  = (32'(room) < 32'(MAX_BURST)) ? 32'(room) : 32'(MAX_BURST);
        if (32'(rem) < lim) lim = 32'(rem);
        return 9'(lim);
    endfunction

    assign next_addr  = addr_q + (AXI_WIDTH_AD'(len_q) << SIZE);
    assign len_start  = calc_len(base_addr[11:0], num_words);
    assign len_next   = calc_len(next_addr[11:0], rem_q);
    assign unused_bid = ^M_AXI_RST_BID;

    // Every channel transfers on a cycle where valid and ready are both high;
    // a raised valid is held with stable payload until that cycle.
    assign w_fire = (state == DATA) && in_valid && M_AXI_RST_WREADY;

    assign M_AXI_RST_AWID    = AXI_WIDTH_ID'(AXI_ID);
    assign M_AXI_RST_AWSIZE  = 3'(SIZE);
    assign M_AXI_RST_AWBURST = 2'b01;
    assign M_AXI_RST_AWADDR  = awaddr_q;
    assign M_AXI_RST_AWLEN   = awlen_q;
    assign M_AXI_RST_AWVALID = awvalid_q;
    assign M_AXI_RST_WDATA   = in_data;
    assign M_AXI_RST_WSTRB   = '1;
    assign M_AXI_RST_WVALID  = (state == DATA) && in_valid;
    assign M_AXI_RST_WLAST   = (state == DATA) && (beat_q == 9'd1);
    assign in_ready          = (state == DATA) && M_AXI_RST_WREADY;
    assign M_AXI_RST_BREADY  = (state == RESP);
    assign busy              = (state != IDLE);
    assign done              = done_q;
    assign error             = error_q;
    assign state_dbg         = state;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error_q <= 1'b0;
                        if (num_words == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q    <= base_addr;
                            rem_q     <= num_words;
                            len_q     <= len_start;
                            awaddr_q  <= base_addr;
                            awlen_q   <= 8'(len_start - 9'd1);
                            awvalid_q <= 1'b1;
                            state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (M_AXI_RST_AWREADY) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= len_q;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        beat_q <= beat_q - 9'd1;
                        rem_q  <= rem_q - CNT_WIDTH'(1);
                        if (beat_q == 9'd1) state <= RESP;
                    end
                end
                RESP: begin
                    if (M_AXI_RST_BVALID) begin
                        if (M_AXI_RST_BRESP != 2'b00) error_q <= 1'b1;
                        addr_q <= next_addr;
                        if (rem_q == '0) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            len_q     <= len_next;
                            awaddr_q  <= next_addr;
                            awlen_q   <= 8'(len_next - 9'd1);
                            awvalid_q <= 1'b1;
                            state     <= ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_convolution_2d_result_writer.sv
// Self-checking bench for convolution_2d_result_writer: scoreboarded AW and W traffic
// against a randomly stalling memory slave, plus reset, zero-count and error scenarios.
module tb_convolution_2d_result_writer;

    localparam int ID = 4;
    localparam int AD = 32;
    localparam int DA = 32;
    localparam int DS = 4;
    localparam int CW = 16;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          start = 1'b0;
    logic [AD-1:0] base_addr = '0;
    logic [CW-1:0] num_words = '0;
    logic          busy, done, error;
    logic [DA-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [ID-1:0] M_AXI_RST_AWID;
    logic [AD-1:0] M_AXI_RST_AWADDR;
    logic [7:0]    M_AXI_RST_AWLEN;
    logic [2:0]    M_AXI_RST_AWSIZE;
    logic [1:0]    M_AXI_RST_AWBURST;
    logic          M_AXI_RST_AWVALID;
    logic          M_AXI_RST_AWREADY = 1'b0;
    logic [DA-1:0] M_AXI_RST_WDATA;
    logic [DS-1:0] M_AXI_RST_WSTRB;
    logic          M_AXI_RST_WLAST;
    logic          M_AXI_RST_WVALID;
    logic          M_AXI_RST_WREADY = 1'b0;
    logic [ID-1:0] M_AXI_RST_BID = '0;
    logic [1:0]    M_AXI_RST_BRESP = 2'b00;
    logic          M_AXI_RST_BVALID = 1'b0;
    logic          M_AXI_RST_BREADY;
    logic [1:0]    state_dbg;

    convolution_2d_result_writer dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .error(error),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .M_AXI_RST_AWID(M_AXI_RST_AWID), .M_AXI_RST_AWADDR(M_AXI_RST_AWADDR),
        .M_AXI_RST_AWLEN(M_AXI_RST_AWLEN), .M_AXI_RST_AWSIZE(M_AXI_RST_AWSIZE),
        .M_AXI_RST_AWBURST(M_AXI_RST_AWBURST), .M_AXI_RST_AWVALID(M_AXI_RST_AWVALID),
        .M_AXI_RST_AWREADY(M_AXI_RST_AWREADY), .M_AXI_RST_WDATA(M_AXI_RST_WDATA),
        .M_AXI_RST_WSTRB(M_AXI_RST_WSTRB), .M_AXI_RST_WLAST(M_AXI_RST_WLAST),
        .M_AXI_RST_WVALID(M_AXI_RST_WVALID), .M_AXI_RST_WREADY(M_AXI_RST_WREADY),
        .M_AXI_RST_BID(M_AXI_RST_BID), .M_AXI_RST_BRESP(M_AXI_RST_BRESP),
        .M_AXI_RST_BVALID(M_AXI_RST_BVALID), .M_AXI_RST_BREADY(M_AXI_RST_BREADY),
        .state_dbg(state_dbg)
    );

    // clock
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    logic [DA-1:0] exp_q[$];
    logic [DA-1:0] src_q[$];
    logic [39:0]   exp_aw_q[$];
    logic [39:0]   exp_aw;
    logic [DA-1:0] exp_w;

    bit            mon_en = 1'b0;
    int            stall_pct = 0;
    int            err_burst = -1;
    int            b_idx = 0;
    bit            b_pending = 1'b0;
    int            beats_left = 0;
    int            done_cnt = 0;
    int            aw_hs_cnt = 0;
    int            awvalid_cnt = 0;
    int            wbeat_cnt = 0;
    int            wlast_cnt = 0;
    bit            prev_aw_stall = 1'b0;
    logic [AD-1:0] prev_awaddr = '0;
    logic [7:0]    prev_awlen = '0;

    // Memory slave, stream source and scoreboard: drive on the falling edge,
    // sample 1 ns later, the handshake takes effect on the next rising edge.
    initial forever begin
        @(negedge ACLK);
        M_AXI_RST_AWREADY = ($urandom_range(0, 99) >= stall_pct);
        M_AXI_RST_WREADY  = ($urandom_range(0, 99) >= stall_pct);
        in_valid          = (src_q.size() > 0) && ($urandom_range(0, 99) >= stall_pct);
        in_data           = (src_q.size() > 0) ? src_q[0] : '0;
        M_AXI_RST_BVALID  = b_pending && ($urandom_range(0, 99) >= stall_pct);
        M_AXI_RST_BRESP   = (b_idx == err_burst) ? 2'b10 : 2'b00;
        M_AXI_RST_BID     = '0;
        #1;
        if (mon_en) begin
            if (done) done_cnt++;
            if (M_AXI_RST_AWVALID) awvalid_cnt++;
            if (prev_aw_stall) begin
                checks++;
                if (M_AXI_RST_AWVALID !== 1'b1 || M_AXI_RST_AWADDR !== prev_awaddr ||
                    M_AXI_RST_AWLEN !== prev_awlen) begin
                    errors++;
                    $display("FAIL aw_stable: got valid=%0b addr=%h len=%0d, held addr=%h len=%0d",
                             M_AXI_RST_AWVALID, M_AXI_RST_AWADDR, M_AXI_RST_AWLEN,
                             prev_awaddr, prev_awlen);
                end
            end
            prev_aw_stall = M_AXI_RST_AWVALID && !M_AXI_RST_AWREADY;
            prev_awaddr   = M_AXI_RST_AWADDR;
            prev_awlen    = M_AXI_RST_AWLEN;
            if (M_AXI_RST_AWVALID && M_AXI_RST_AWREADY) begin
                aw_hs_cnt++;
                checks++;
                if (b_pending || beats_left != 0) begin
                    errors++;
                    $display("FAIL aw_outstanding: AW issued with b_pending=%0b beats_left=%0d, need 0/0",
                             b_pending, beats_left);
                end
                checks++;
                if (exp_aw_q.size() == 0) begin
                    errors++;
                    $display("FAIL aw_unexpected: addr=%h len=%0d, none expected",
                             M_AXI_RST_AWADDR, M_AXI_RST_AWLEN);
                end else begin
                    exp_aw = exp_aw_q.pop_front();
                    if ({M_AXI_RST_AWADDR, M_AXI_RST_AWLEN} !== exp_aw) begin
                        errors++;
                        $display("FAIL aw_seq: got addr=%h len=%0d, need addr=%h len=%0d",
                                 M_AXI_RST_AWADDR, M_AXI_RST_AWLEN, exp_aw[39:8], exp_aw[7:0]);
                    end
                    beats_left = int'(exp_aw[7:0]) + 1;
                end
            end
            if (M_AXI_RST_WVALID && M_AXI_RST_WREADY) begin
                wbeat_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL w_unexpected: data=%h, none expected", M_AXI_RST_WDATA);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (M_AXI_RST_WDATA !== exp_w) begin
                        errors++;
                        $display("FAIL w_data: got %h, need %h", M_AXI_RST_WDATA, exp_w);
                    end
                end
                checks++;
                if (M_AXI_RST_WLAST !== (beats_left == 1)) begin
                    errors++;
                    $display("FAIL w_last: got %0b, need %0b (beats_left=%0d)",
                             M_AXI_RST_WLAST, (beats_left == 1), beats_left);
                end
                if (beats_left > 0) beats_left--;
                if (M_AXI_RST_WLAST) begin
                    wlast_cnt++;
                    b_pending = 1'b1;
                end
            end
            if (in_valid && in_ready) void'(src_q.pop_front());
            if (M_AXI_RST_BVALID && M_AXI_RST_BREADY) begin
                b_pending = 1'b0;
                b_idx++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_words(input int n);
        logic [DA-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            src_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic model_bursts(input logic [AD-1:0] b, input int n);
        logic [AD-1:0] a;
        int rem;
        int room;
        int len;
        a = b;
        rem = n;
        while (rem > 0) begin
            room = (4096 - int'(a[11:0])) / DS;
            len = rem;
            if (len > 16) len = 16;
            if (len > room) len = room;
            exp_aw_q.push_back({a, 8'(len - 1)});
            a = a + AD'(len * DS);
            rem = rem - len;
        end
    endtask

    task automatic start_xfer(input logic [AD-1:0] b, input logic [CW-1:0] n);
        @(negedge ACLK); #2;
        start = 1'b1;
        base_addr = b;
        num_words = n;
        @(negedge ACLK); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge ACLK); #2;
            k++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        #2;
        checks++;
        if ({M_AXI_RST_AWVALID, M_AXI_RST_WVALID, M_AXI_RST_WLAST, M_AXI_RST_BREADY,
             in_ready, busy, done, error} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got awv=%0b wv=%0b wl=%0b br=%0b rdy=%0b busy=%0b done=%0b err=%0b, need all 0",
                     M_AXI_RST_AWVALID, M_AXI_RST_WVALID, M_AXI_RST_WLAST, M_AXI_RST_BREADY,
                     in_ready, busy, done, error);
        end
        checks++;
        if (M_AXI_RST_AWADDR !== 32'h0 || M_AXI_RST_AWLEN !== 8'h0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: got addr=%h len=%0d state=%0d, need 0/0/0",
                     M_AXI_RST_AWADDR, M_AXI_RST_AWLEN, state_dbg);
        end
        checks++;
        if (M_AXI_RST_AWID !== 4'd0 || M_AXI_RST_AWSIZE !== 3'd2 ||
            M_AXI_RST_AWBURST !== 2'b01 || M_AXI_RST_WSTRB !== 4'hF) begin
            errors++;
            $display("FAIL constants: got id=%0d size=%0d burst=%0d strb=%h, need 0/2/1/f",
                     M_AXI_RST_AWID, M_AXI_RST_AWSIZE, M_AXI_RST_AWBURST, M_AXI_RST_WSTRB);
        end
        ARESET = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_bursting;
        int d0;
        int l0;
        stall_pct = 0;
        err_burst = -1;
        b_idx = 0;
        exp_aw_q.push_back({32'h0000_1000, 8'd15});
        exp_aw_q.push_back({32'h0000_1040, 8'd15});
        exp_aw_q.push_back({32'h0000_1080, 8'd7});
        push_words(40);
        d0 = done_cnt;
        l0 = wlast_cnt;
        start_xfer(32'h0000_1000, 16'd40);
        checks++;
        if (busy !== 1'b1 || M_AXI_RST_AWVALID !== 1'b1) begin
            errors++;
            $display("FAIL burst_start: got busy=%0b awvalid=%0b one cycle after start, need 1/1",
                     busy, M_AXI_RST_AWVALID);
        end
        wait_done("burst", 400);
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: got busy=%0b error=%0b at done, need 0/0", busy, error);
        end
        checks++;
        if (exp_aw_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL burst_drain: got %0d AW and %0d words left, need 0/0",
                     exp_aw_q.size(), exp_q.size());
        end
        checks++;
        if (wlast_cnt - l0 != 3) begin
            errors++;
            $display("FAIL burst_wlast: got %0d WLAST beats, need 3", wlast_cnt - l0);
        end
        repeat (3) @(negedge ACLK);
        #2;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL burst_done_once: got %0d done pulses, need 1", done_cnt - d0);
        end
    endtask

    task automatic test_4k_split;
        b_idx = 0;
        exp_aw_q.push_back({32'h0000_0FF8, 8'd1});
        exp_aw_q.push_back({32'h0000_1000, 8'd7});
        push_words(10);
        start_xfer(32'h0000_0FF8, 16'd10);
        wait_done("split", 200);
        checks++;
        if (exp_aw_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL split_drain: got %0d AW and %0d words left, need 0/0",
                     exp_aw_q.size(), exp_q.size());
        end
    endtask

    task automatic test_zero_count;
        int a0;
        int d0;
        a0 = awvalid_cnt;
        d0 = done_cnt;
        start_xfer(32'h0000_0100, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%0b busy=%0b one cycle after start, need 1/0", done, busy);
        end
        @(negedge ACLK); #2;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: got done=%0b two cycles after start, need 0", done);
        end
        repeat (5) @(negedge ACLK);
        #2;
        checks++;
        if (awvalid_cnt != a0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL zero_traffic: got %0d AWVALID cycles and %0d done pulses, need 0/1",
                     awvalid_cnt - a0, done_cnt - d0);
        end
    endtask

    task automatic test_error_resp;
        b_idx = 0;
        err_burst = 0;
        exp_aw_q.push_back({32'h0000_2000, 8'd15});
        exp_aw_q.push_back({32'h0000_2040, 8'd15});
        push_words(32);
        start_xfer(32'h0000_2000, 16'd32);
        wait_done("err", 400);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got error=%0b at done, need 1", error);
        end
        checks++;
        if (exp_aw_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL err_continue: got %0d AW and %0d words left, need 0/0",
                     exp_aw_q.size(), exp_q.size());
        end
        err_burst = -1;
        start_xfer(32'h0000_0000, 16'd0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got error=%0b after new start, need 0", error);
        end
    endtask

    task automatic test_backpressure;
        b_idx = 0;
        stall_pct = 40;
        model_bursts(32'h0000_3F80, 100);
        push_words(100);
        start_xfer(32'h0000_3F80, 16'd100);
        wait_done("bp", 4000);
        checks++;
        if (exp_aw_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d AW and %0d words left, need 0/0",
                     exp_aw_q.size(), exp_q.size());
        end
        stall_pct = 0;
    endtask

    task automatic test_reset_mid_burst;
        int w0;
        int k;
        int d0;
        int h0;
        b_idx = 0;
        exp_aw_q.push_back({32'h0000_5000, 8'd15});
        push_words(20);
        start_xfer(32'h0000_5000, 16'd20);
        w0 = wbeat_cnt;
        k = 0;
        while (wbeat_cnt - w0 < 4 && k < 50) begin
            @(negedge ACLK); #2;
            k++;
        end
        checks++;
        if (wbeat_cnt - w0 < 4) begin
            errors++;
            $display("FAIL rst_reach_beat: got %0d beats within 50 cycles, need 4", wbeat_cnt - w0);
        end
        mon_en = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK); #2;
        checks++;
        if ({M_AXI_RST_AWVALID, M_AXI_RST_WVALID, M_AXI_RST_WLAST, M_AXI_RST_BREADY,
             in_ready, busy, done, error} !== 8'h00 ||
            M_AXI_RST_AWADDR !== 32'h0 || M_AXI_RST_AWLEN !== 8'h0) begin
            errors++;
            $display("FAIL rst_mid: got awv=%0b wv=%0b wl=%0b br=%0b rdy=%0b busy=%0b done=%0b addr=%h len=%0d, need all 0",
                     M_AXI_RST_AWVALID, M_AXI_RST_WVALID, M_AXI_RST_WLAST, M_AXI_RST_BREADY,
                     in_ready, busy, done, M_AXI_RST_AWADDR, M_AXI_RST_AWLEN);
        end
        exp_q.delete();
        src_q.delete();
        exp_aw_q.delete();
        b_pending = 1'b0;
        beats_left = 0;
        prev_aw_stall = 1'b0;
        ARESET = 1'b0;
        mon_en = 1'b1;

        b_idx = 0;
        exp_aw_q.push_back({32'h0000_6000, 8'd15});
        exp_aw_q.push_back({32'h0000_6040, 8'd3});
        push_words(20);
        d0 = done_cnt;
        start_xfer(32'h0000_6000, 16'd20);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart: got busy=%0b after start, need 1", busy);
        end
        repeat (3) @(negedge ACLK);
        #2;
        start = 1'b1;
        base_addr = 32'h0000_7000;
        num_words = 16'd5;
        @(negedge ACLK); #2;
        start = 1'b0;
        wait_done("rst_restart", 300);
        h0 = aw_hs_cnt;
        checks++;
        if (exp_aw_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_restart_drain: got %0d AW and %0d words left, need 0/0",
                     exp_aw_q.size(), exp_q.size());
        end
        repeat (10) @(negedge ACLK);
        #2;
        checks++;
        if (aw_hs_cnt != h0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL busy_start_ignored: got %0d extra AW, busy=%0b, %0d done pulses, need 0/0/1",
                     aw_hs_cnt - h0, busy, done_cnt - d0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bursting();
        test_4k_split();
        test_zero_count();
        test_error_resp();
        test_backpressure();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
